// File: rtl/sqrt_pkg.sv
// Width and mask helpers shared by the streaming square-root block.
// No types are exported; every width is passed explicitly as a parameter.
//   popcount(mask) : number of set bits, gives the pipeline latency
//   root_w(dw, fb) : root width, DATAWIDTH/2 + FRAC_BITS
//   rem_w(dw, fb)  : remainder width, root width + 1
package sqrt_pkg;

  function automatic int popcount(input logic [63:0] mask);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (mask[i]) n++;
    end
    return n;
  endfunction

  function automatic int root_w(input int dw, input int fb);
    return dw / 2 + fb;
  endfunction

  function automatic int rem_w(input int dw, input int fb);
    return root_w(dw, fb) + 1;
  endfunction

endpackage

// File: rtl/sqrt_iter_step.sv
// One combinational iteration of the digit-by-digit square root.
// Brings down the next two radicand bits, trial-subtracts {q, 01} from the
// partial remainder and appends the resulting root bit.
// Ports:
//   ac_in  / ac_out : partial remainder, ITER+2 bits
//   x_in   / x_out  : remaining radicand bits, MSB-first, 2*ITER bits
//   q_in   / q_out  : partial root, ITER bits
module sqrt_iter_step #(
  parameter int ITER = 4
) (
  input  logic [ITER+1:0]   ac_in,
  input  logic [2*ITER-1:0] x_in,
  input  logic [ITER-1:0]   q_in,
  output logic [ITER+1:0]   ac_out,
  output logic [2*ITER-1:0] x_out,
  output logic [ITER-1:0]   q_out
);

  logic [ITER+1:0] ac_sh;
  logic [ITER+2:0] test;
  logic [ITER:0]   q_ext;
  logic            take;
  logic            unused_bits;

  // Before any iteration the remainder is at most 2*q < 2^ITER, so its two
  // top bits are always zero and can be shifted out.
  assign ac_sh = {ac_in[ITER-1:0], x_in[2*ITER-1 -: 2]};

  // One extra bit on the subtraction so the shifted remainder can use the
  // full accumulator width without colliding with the sign.
  assign test = {1'b0, ac_sh} - {1'b0, q_in, 2'b01};
  assign take = ~test[ITER+2];

  assign ac_out = take ? test[ITER+1:0] : ac_sh;
  assign x_out  = x_in << 2;

  // The partial root never fills its MSB before the last step, so the
  // shifted-out bit is always zero.
  assign q_ext = {q_in, take};
  assign q_out = q_ext[ITER-1:0];

  assign unused_bits = ^{ac_in[ITER+1:ITER], q_ext[ITER]};

endmodule

// File: rtl/sqrt_int_stream.sv
// Pipelined integer / fixed-point square root with valid/ready streaming.
// o_root = floor(sqrt(i_rad * 4^FRAC_BITS)), o_rem = i_rad * 4^FRAC_BITS - o_root^2.
// A sideband tag travels with each operand. PIPE_MASK picks which of the
// ITER+2 slot boundaries hold a register (bit 0 input, bits 1..ITER after
// each iteration, bit ITER+1 output); latency equals its popcount.
//
// Handshake: an operand transfers on a rising edge where i_valid & i_ready,
// a result transfers where o_valid & o_ready. The pipeline stalls globally
// while o_valid & ~o_ready: every register holds, i_ready is low, and the
// outputs stay stable. Bubbles advance like data. With no registers the
// block is combinational and i_ready simply follows o_ready.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_valid, i_ready  input handshake
//   i_rad, i_tag      radicand and tag
//   o_valid, o_ready  output handshake
//   o_root, o_rem     root and remainder
//   o_tag             tag of the operand behind this result
//   o_busy            any enabled register holds a valid operand
module sqrt_int_stream
  import sqrt_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int FRAC_BITS = 0,
  parameter int TAG_W     = 1,
  parameter     PIPE_MASK = {(DATAWIDTH / 2 + FRAC_BITS + 2){1'b1}}
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    i_valid,
  output logic                                    i_ready,
  input  logic [DATAWIDTH-1:0]                    i_rad,
  input  logic [TAG_W-1:0]                        i_tag,
  output logic                                    o_valid,
  input  logic                                    o_ready,
  output logic [root_w(DATAWIDTH, FRAC_BITS)-1:0] o_root,
  output logic [rem_w(DATAWIDTH, FRAC_BITS)-1:0]  o_rem,
  output logic [TAG_W-1:0]                        o_tag,
  output logic                                    o_busy
);

  localparam int ITER   = DATAWIDTH / 2 + FRAC_BITS;
  localparam int ROOT_W = root_w(DATAWIDTH, FRAC_BITS);
  localparam int REM_W  = rem_w(DATAWIDTH, FRAC_BITS);
  localparam int ACW    = REM_W + 1;
  localparam int XW     = 2 * ITER;
  localparam int NSLOT  = ITER + 2;
  localparam int LAT    = popcount(64'(PIPE_MASK));

  if (DATAWIDTH < 2 || (DATAWIDTH % 2) != 0) begin : g_bad_width
    $error("sqrt_int_stream: DATAWIDTH must be even and at least 2");
  end
  if ($bits(PIPE_MASK) != ITER + 2) begin : g_bad_mask
    $error("sqrt_int_stream: PIPE_MASK width must be ITER+2");
  end
  if (ITER + 2 > 64) begin : g_bad_depth
    $error("sqrt_int_stream: pipeline deeper than 64 slots not supported");
  end

  // a_* feeds slot k, b_* is what slot k presents downstream (registered
  // or passed through depending on PIPE_MASK[k]).
  logic             a_v   [NSLOT];
  logic [ACW-1:0]   a_ac  [NSLOT];
  logic [XW-1:0]    a_x   [NSLOT];
  logic [ROOT_W-1:0] a_q  [NSLOT];
  logic [TAG_W-1:0] a_tag [NSLOT];

  logic             b_v   [NSLOT];
  logic [ACW-1:0]   b_ac  [NSLOT];
  logic [XW-1:0]    b_x   [NSLOT];
  logic [ROOT_W-1:0] b_q  [NSLOT];
  logic [TAG_W-1:0] b_tag [NSLOT];

  logic [NSLOT-1:0] reg_v;
  logic             stall;
  logic             unused_bits;

  // Slot 0 input: radicand left-aligned with 2*FRAC_BITS zero bits below it.
  assign a_v[0]   = i_valid;
  assign a_ac[0]  = '0;
  assign a_x[0]   = XW'(i_rad) << (2 * FRAC_BITS);
  assign a_q[0]   = '0;
  assign a_tag[0] = i_tag;

  for (genvar k = 1; k <= ITER; k++) begin : g_iter
    sqrt_iter_step #(
      .ITER(ITER)
    ) u_step (
      .ac_in (b_ac[k-1]),
      .x_in  (b_x[k-1]),
      .q_in  (b_q[k-1]),
      .ac_out(a_ac[k]),
      .x_out (a_x[k]),
      .q_out (a_q[k])
    );
    assign a_v[k]   = b_v[k-1];
    assign a_tag[k] = b_tag[k-1];
  end

  // Output slot sees the finished root and remainder unchanged.
  assign a_v[NSLOT-1]   = b_v[ITER];
  assign a_ac[NSLOT-1]  = b_ac[ITER];
  assign a_x[NSLOT-1]   = b_x[ITER];
  assign a_q[NSLOT-1]   = b_q[ITER];
  assign a_tag[NSLOT-1] = b_tag[ITER];

  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    if (PIPE_MASK[k]) begin : g_reg
      logic              v_q;
      logic [ACW-1:0]    ac_q;
      logic [XW-1:0]     x_q;
      logic [ROOT_W-1:0] q_q;
      logic [TAG_W-1:0]  tag_q;

      // Data only loads with a valid operand so the outputs keep their
      // reset/last-result value across bubbles.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q   <= 1'b0;
          ac_q  <= '0;
          x_q   <= '0;
          q_q   <= '0;
          tag_q <= '0;
        end else if (!stall) begin
          v_q <= a_v[k];
          if (a_v[k]) begin
            ac_q  <= a_ac[k];
            x_q   <= a_x[k];
            q_q   <= a_q[k];
            tag_q <= a_tag[k];
          end
        end
      end

      assign b_v[k]   = v_q;
      assign b_ac[k]  = ac_q;
      assign b_x[k]   = x_q;
      assign b_q[k]   = q_q;
      assign b_tag[k] = tag_q;
      assign reg_v[k] = v_q;
    end else begin : g_wire
      assign b_v[k]   = a_v[k];
      assign b_ac[k]  = a_ac[k];
      assign b_x[k]   = a_x[k];
      assign b_q[k]   = a_q[k];
      assign b_tag[k] = a_tag[k];
      assign reg_v[k] = 1'b0;
    end
  end

  assign o_valid = b_v[NSLOT-1];
  assign o_root  = b_q[NSLOT-1];
  // Final remainder is at most 2*root, so the accumulator MSB is always zero.
  assign o_rem   = b_ac[NSLOT-1][REM_W-1:0];
  assign o_tag   = b_tag[NSLOT-1];
  assign o_busy  = |reg_v;

  assign stall = o_valid & ~o_ready;

  if (LAT == 0) begin : g_comb_ready
    assign i_ready = o_ready;
  end else begin : g_pipe_ready
    assign i_ready = ~stall;
  end

  assign unused_bits = ^{b_x[NSLOT-1], b_ac[NSLOT-1][ACW-1], stall};

endmodule

// File: tb/tb_sqrt_int_stream.sv
// Bench for sqrt_int_stream: five instances covering the default pipeline,
// fractional bits, and three register masks, checked against an
// arithmetic square-root model and hand-derived constants.
module tb_sqrt_int_stream;

  localparam int ND = 5;
  localparam int lat_t [ND] = '{6, 10, 0, 2, 3};
  localparam int fb_t  [ND] = '{0, 4, 0, 0, 0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv   [ND];
  logic       ir   [ND];
  logic       ov   [ND];
  logic       ordy [ND];
  logic       busy [ND];
  logic [7:0] irad [ND];
  logic [3:0] itag [ND];
  logic [3:0] otag [ND];
  logic [7:0] oroot[ND];
  logic [8:0] orem [ND];

  logic [3:0] root0, root2, root3, root4;
  logic [4:0] rem0, rem2, rem3, rem4;
  logic [7:0] root1;
  logic [8:0] rem1;

  assign oroot[0] = {4'd0, root0};
  assign oroot[1] = root1;
  assign oroot[2] = {4'd0, root2};
  assign oroot[3] = {4'd0, root3};
  assign oroot[4] = {4'd0, root4};
  assign orem[0]  = {4'd0, rem0};
  assign orem[1]  = rem1;
  assign orem[2]  = {4'd0, rem2};
  assign orem[3]  = {4'd0, rem3};
  assign orem[4]  = {4'd0, rem4};

  sqrt_int_stream #(.DATAWIDTH(8), .FRAC_BITS(0), .TAG_W(4)) dut0 (
    .clk(clk), .rst(rst), .i_valid(iv[0]), .i_ready(ir[0]), .i_rad(irad[0]),
    .i_tag(itag[0]), .o_valid(ov[0]), .o_ready(ordy[0]), .o_root(root0),
    .o_rem(rem0), .o_tag(otag[0]), .o_busy(busy[0]));

  sqrt_int_stream #(.DATAWIDTH(8), .FRAC_BITS(4), .TAG_W(4)) dut1 (
    .clk(clk), .rst(rst), .i_valid(iv[1]), .i_ready(ir[1]), .i_rad(irad[1]),
    .i_tag(itag[1]), .o_valid(ov[1]), .o_ready(ordy[1]), .o_root(root1),
    .o_rem(rem1), .o_tag(otag[1]), .o_busy(busy[1]));

  sqrt_int_stream #(.DATAWIDTH(8), .FRAC_BITS(0), .TAG_W(4), .PIPE_MASK(6'b000000)) dut2 (
    .clk(clk), .rst(rst), .i_valid(iv[2]), .i_ready(ir[2]), .i_rad(irad[2]),
    .i_tag(itag[2]), .o_valid(ov[2]), .o_ready(ordy[2]), .o_root(root2),
    .o_rem(rem2), .o_tag(otag[2]), .o_busy(busy[2]));

  sqrt_int_stream #(.DATAWIDTH(8), .FRAC_BITS(0), .TAG_W(4), .PIPE_MASK(6'b100001)) dut3 (
    .clk(clk), .rst(rst), .i_valid(iv[3]), .i_ready(ir[3]), .i_rad(irad[3]),
    .i_tag(itag[3]), .o_valid(ov[3]), .o_ready(ordy[3]), .o_root(root3),
    .o_rem(rem3), .o_tag(otag[3]), .o_busy(busy[3]));

  sqrt_int_stream #(.DATAWIDTH(8), .FRAC_BITS(0), .TAG_W(4), .PIPE_MASK(6'b010101)) dut4 (
    .clk(clk), .rst(rst), .i_valid(iv[4]), .i_ready(ir[4]), .i_rad(irad[4]),
    .i_tag(itag[4]), .o_valid(ov[4]), .o_ready(ordy[4]), .o_root(root4),
    .o_rem(rem4), .o_tag(otag[4]), .o_busy(busy[4]));

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [20:0] exp_q[$];   // {tag[3:0], root[7:0], rem[8:0]}
  int          acc_q[$];   // cycle each operand was accepted
  bit          use_model;
  bit          chk_lat;
  bit          prev_stall;
  logic [7:0]  prev_root;
  logic [8:0]  prev_rem;
  logic [3:0]  prev_tag;
  logic [7:0]  c_rad [8];
  logic [3:0]  c_tag [8];

  // Reference: largest r with r*r <= rad*4^fb, remainder is the difference.
  function automatic logic [20:0] model(input int d, input logic [7:0] rad, input logic [3:0] tag);
    int n;
    int r;
    n = int'(rad) << (2 * fb_t[d]);
    r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return {tag, 8'(r), 9'(n - r * r)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic advance();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) advance();
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    prev_stall = 1'b0;
  endtask

  // Samples instance d shortly after the inputs were applied and scores the
  // handshakes that will complete on the coming rising edge.
  task automatic settle(input int d);
    logic [20:0] e;
    logic        exp_ir;
    int          a;
    #1;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      prev_stall = 1'b0;
      return;
    end
    exp_ir = (lat_t[d] == 0) ? ordy[d] : !(ov[d] && !ordy[d]);
    n_cmp++;
    if (ir[d] !== exp_ir) begin
      n_fail++;
      $display("FAIL i_ready dut%0d cyc%0d: got %b expected %b", d, cyc, ir[d], exp_ir);
    end
    if (prev_stall) begin
      n_cmp++;
      if (ov[d] !== 1'b1 || oroot[d] !== prev_root || orem[d] !== prev_rem || otag[d] !== prev_tag) begin
        n_fail++;
        $display("FAIL stable dut%0d cyc%0d: got v%b r%0d m%0d t%0d expected v1 r%0d m%0d t%0d",
                 d, cyc, ov[d], oroot[d], orem[d], otag[d], prev_root, prev_rem, prev_tag);
      end
    end
    if (iv[d] && ir[d]) begin
      if (use_model) exp_q.push_back(model(d, irad[d], itag[d]));
      acc_q.push_back(cyc);
    end
    if (ov[d] === 1'b1 && ordy[d]) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out dut%0d cyc%0d: got r%0d m%0d t%0d expected no result",
                 d, cyc, oroot[d], orem[d], otag[d]);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        if (otag[d] !== e[20:17] || oroot[d] !== e[16:9] || orem[d] !== e[8:0]) begin
          n_fail++;
          $display("FAIL result dut%0d cyc%0d: got r%0d m%0d t%0d expected r%0d m%0d t%0d",
                   d, cyc, oroot[d], orem[d], otag[d], e[16:9], e[8:0], e[20:17]);
        end
        if (chk_lat) begin
          n_cmp++;
          if (cyc - a != lat_t[d]) begin
            n_fail++;
            $display("FAIL latency dut%0d: got %0d expected %0d", d, cyc - a, lat_t[d]);
          end
        end
      end
    end
    prev_stall = ov[d] && !ordy[d];
    prev_root  = oroot[d];
    prev_rem   = orem[d];
    prev_tag   = otag[d];
  endtask

  task automatic tick(input int d);
    settle(d);
    advance();
  endtask

  task automatic drain(input int d, input string name);
    iv[d]   = 1'b0;
    ordy[d] = 1'b1;
    repeat (lat_t[d] + 4) tick(d);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain dut%0d: got %0d results outstanding expected 0", name, d, exp_q.size());
    end
  endtask

  // Streams n operands (held until accepted) with random gaps and o_ready.
  task automatic run_ops(input int d, input int n, input bit exh, input int rdy_pct, input string name);
    int k;
    int guard;
    bit acc;
    k = 0;
    guard = 0;
    use_model = 1'b1;
    prev_stall = 1'b0;
    iv[d] = 1'b0;
    while (k < n && guard < n * 20) begin
      if (!iv[d] && $urandom_range(0, 99) < 80) begin
        iv[d]   = 1'b1;
        irad[d] = exh ? 8'(k) : 8'($urandom_range(0, 255));
        itag[d] = 4'($urandom_range(0, 15));
      end
      ordy[d] = ($urandom_range(0, 99) < rdy_pct);
      settle(d);
      acc = iv[d] && ir[d];
      advance();
      if (acc) begin
        k++;
        iv[d] = 1'b0;
      end
      guard++;
    end
    n_cmp++;
    if (k != n) begin
      n_fail++;
      $display("FAIL %s_accept dut%0d: got %0d accepted expected %0d", name, d, k, n);
    end
    drain(d, name);
  endtask

  // Feeds c_rad/c_tag[0..n-1] back to back with o_ready high; expectations
  // are pushed by the caller.
  task automatic run_const(input int d, input int n, input string name);
    int k;
    bit acc;
    k = 0;
    use_model = 1'b0;
    chk_lat = 1'b1;
    prev_stall = 1'b0;
    ordy[d] = 1'b1;
    for (int c = 0; c < n + lat_t[d] + 6; c++) begin
      if (k < n) begin
        iv[d]   = 1'b1;
        irad[d] = c_rad[k];
        itag[d] = c_tag[k];
      end else begin
        iv[d] = 1'b0;
      end
      settle(d);
      acc = iv[d] && ir[d];
      advance();
      if (acc) k++;
    end
    n_cmp++;
    if (k != n || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_count dut%0d: got %0d accepted %0d left expected %0d accepted 0 left",
               name, d, k, exp_q.size(), n);
    end
    chk_lat = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    for (int d = 0; d < ND; d++) begin
      n_cmp++;
      if (ov[d] !== 1'b0 || busy[d] !== 1'b0 || oroot[d] !== 8'd0 || orem[d] !== 9'd0 || otag[d] !== 4'd0) begin
        n_fail++;
        $display("FAIL reset dut%0d: got v%b b%b r%0d m%0d t%0d expected all 0",
                 d, ov[d], busy[d], oroot[d], orem[d], otag[d]);
      end
    end
    advance();
  endtask

  task automatic test_directed();
    c_rad[0] = 8'd255; c_tag[0] = 4'd1; exp_q.push_back({4'd1, 8'd15, 9'd30});
    c_rad[1] = 8'd144; c_tag[1] = 4'd2; exp_q.push_back({4'd2, 8'd12, 9'd0});
    c_rad[2] = 8'd0;   c_tag[2] = 4'd3; exp_q.push_back({4'd3, 8'd0,  9'd0});
    c_rad[3] = 8'd1;   c_tag[3] = 4'd4; exp_q.push_back({4'd4, 8'd1,  9'd0});
    run_const(0, 4, "directed");
  endtask

  task automatic test_frac();
    // 2*256 = 512 -> 22 (1.375), 512-484 = 28; 255*256 = 65280 -> 255, 65280-65025 = 255
    c_rad[0] = 8'd2;   c_tag[0] = 4'd5; exp_q.push_back({4'd5, 8'd22,  9'd28});
    c_rad[1] = 8'd255; c_tag[1] = 4'd6; exp_q.push_back({4'd6, 8'd255, 9'd255});
    c_rad[2] = 8'd0;   c_tag[2] = 4'd7; exp_q.push_back({4'd7, 8'd0,   9'd0});
    c_rad[3] = 8'd1;   c_tag[3] = 4'd8; exp_q.push_back({4'd8, 8'd16,  9'd0});
    run_const(1, 4, "frac");
  endtask

  task automatic test_backpressure();
    int k;
    bit acc;
    k = 0;
    use_model = 1'b1;
    prev_stall = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (k < 8 && !iv[0]) begin
        iv[0]   = 1'b1;
        irad[0] = 8'($urandom_range(0, 255));
        itag[0] = 4'(k);
      end
      ordy[0] = !(c >= 7 && c < 12);
      settle(0);
      if (c >= 7 && c < 12) begin
        n_cmp++;
        if (ir[0] !== 1'b0 || ov[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_stall cyc%0d: got i_ready %b o_valid %b expected 0 1", c, ir[0], ov[0]);
        end
      end
      acc = iv[0] && ir[0];
      advance();
      if (acc) begin
        k++;
        iv[0] = 1'b0;
      end
    end
    n_cmp++;
    if (k != 8) begin
      n_fail++;
      $display("FAIL bp_accept: got %0d expected 8", k);
    end
    drain(0, "bp");
  endtask

  task automatic test_reset_mid();
    use_model = 1'b1;
    prev_stall = 1'b0;
    ordy[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      iv[0]   = 1'b1;
      irad[0] = 8'($urandom_range(1, 255));
      itag[0] = 4'(c + 9);
      tick(0);
    end
    iv[0] = 1'b0;
    rst = 1'b1;
    tick(0);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ov[0] !== 1'b0 || busy[0] !== 1'b0 || oroot[0] !== 8'd0 || orem[0] !== 9'd0 || otag[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got v%b b%b r%0d m%0d t%0d expected all 0",
               ov[0], busy[0], oroot[0], orem[0], otag[0]);
    end
    advance();
    repeat (12) tick(0);
    n_cmp++;
    if (busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_busy: got %b expected 0", busy[0]);
    end
  endtask

  task automatic test_busy();
    logic exp_b;
    use_model = 1'b1;
    prev_stall = 1'b0;
    ordy[0] = 1'b1;
    irad[0] = 8'($urandom_range(0, 255));
    itag[0] = 4'd3;
    for (int c = 0; c < 12; c++) begin
      iv[0] = (c == 0);
      settle(0);
      exp_b = (c >= 1 && c <= 6);
      n_cmp++;
      if (busy[0] !== exp_b) begin
        n_fail++;
        $display("FAIL busy cyc%0d: got %b expected %b", c, busy[0], exp_b);
      end
      advance();
    end
  endtask

  task automatic test_mask_sweep();
    for (int d = 2; d < ND; d++) begin
      chk_lat = 1'b1;
      run_ops(d, 6, 1'b0, 100, "mask_lat");
      chk_lat = 1'b0;
      run_ops(d, 256, 1'b1, 70, "mask_exh");
    end
  endtask

  task automatic test_random();
    chk_lat = 1'b0;
    run_ops(0, 150, 1'b0, 60, "rand0");
    run_ops(1, 150, 1'b0, 60, "rand1");
    chk_lat = 1'b1;
    run_ops(1, 40, 1'b0, 100, "rand1_lat");
    chk_lat = 1'b0;
  endtask

  // ---------------- main ----------------
  initial begin
    rst = 1'b1;
    use_model = 1'b1;
    chk_lat = 1'b0;
    prev_stall = 1'b0;
    for (int d = 0; d < ND; d++) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b1;
      irad[d] = 8'd0;
      itag[d] = 4'd0;
    end
    @(negedge clk);
    test_reset();
    test_directed();
    test_frac();
    test_backpressure();
    test_reset_mid();
    test_busy();
    test_mask_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
